id_ex_stage_reg: RTL and testbench

//  ID/EX pipeline register with integrated load-use hazard detection. Captures decoded

---
 rtl/id_ex_stage_reg.sv | 148 ++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, backpressure hold,
// branch-flush squash and a saturating load-use bubble counter.
module id_ex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic [4:0]        id_rd_addr,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              id_ex_valid,
  output logic [XLEN-1:0]   id_ex_pc,
  output logic [4:0]        id_ex_rs1_addr,
  output logic [4:0]        id_ex_rs2_addr,
  output logic [4:0]        id_ex_rd_addr,
  output logic [XLEN-1:0]   id_ex_rs1_data,
  output logic [XLEN-1:0]   id_ex_rs2_data,
  output logic [XLEN-1:0]   id_ex_imm,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              id_ex_reg_write,
  output logic              id_ex_mem_read,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [4:0]        rs1_addr_q, rs1_addr_d;
  logic [4:0]        rs2_addr_q, rs2_addr_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic rs1_hit, rs2_hit, hazard;

  // x0 destinations and unused sources can never create a dependency
  always_comb begin
    rs1_hit = id_uses_rs1 && (id_rs1_addr == rd_addr_q);
    rs2_hit = id_uses_rs2 && (id_rs2_addr == rd_addr_q);
    hazard  = valid_q && mem_read_q && (rd_addr_q != 5'd0) && id_valid && (rs1_hit || rs2_hit);
  end

  assign load_use_stall = hazard;
  assign id_ready       = flush || (ex_ready && !hazard);

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    ctrl_d      = ctrl_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    if (flush || (ex_ready && (hazard || !id_valid))) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
    end else if (ex_ready) begin
      valid_d     = 1'b1;
      pc_d        = id_pc;
      rs1_addr_d  = id_rs1_addr;
      rs2_addr_d  = id_rs2_addr;
      rd_addr_d   = id_rd_addr;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      ctrl_d      = id_ctrl;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hazard && ex_ready && !flush && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      ctrl_q      <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      ctrl_q      <= ctrl_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      cnt_q       <= cnt_d;
    end
  end

  assign id_ex_valid     = valid_q;
  assign id_ex_pc        = pc_q;
  assign id_ex_rs1_addr  = rs1_addr_q;
  assign id_ex_rs2_addr  = rs2_addr_q;
  assign id_ex_rd_addr   = rd_addr_q;
  assign id_ex_rs1_data  = rs1_data_q;
  assign id_ex_rs2_data  = rs2_data_q;
  assign id_ex_imm       = imm_q;
  assign id_ex_ctrl      = ctrl_q;
  assign id_ex_reg_write = reg_write_q;
  assign id_ex_mem_read  = mem_read_q;
  assign stall_count     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: a spec-level model pushes expected register
// contents per edge into a scoreboard queue, popped and compared after the edge.
module tb_id_ex_stage_reg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 12;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst, id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
  logic              ex_ready, flush;
  logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]        id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_ready, id_ex_valid, id_ex_reg_write, id_ex_mem_read, load_use_stall;
  logic [XLEN-1:0]   id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]        id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic [CNT_W-1:0]  stall_count;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_ready(ex_ready),
    .flush(flush), .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc),
    .id_ex_rs1_addr(id_ex_rs1_addr), .id_ex_rs2_addr(id_ex_rs2_addr),
    .id_ex_rd_addr(id_ex_rd_addr), .id_ex_rs1_data(id_ex_rs1_data),
    .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm), .id_ex_ctrl(id_ex_ctrl),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .load_use_stall(load_use_stall), .stall_count(stall_count)
  );

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [4:0]        rs1a, rs2a, rda;
    logic [XLEN-1:0]   d1, d2, imm;
    logic [CTRL_W-1:0] ctrl;
    logic              rw, mr;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        m;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          m_known = 0;
  logic [31:0] pc_ctr  = 32'h100;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic u1, input logic u2,
                           input logic rw, input logic mr);
    id_valid = v; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_reg_write = rw; id_mem_read = mr;
    id_pc = pc_ctr; pc_ctr += 32'd4;
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_ctrl = CTRL_W'($urandom);
  endtask

  // One clock: check combinational outputs against the model, predict the edge, compare after it
  task automatic cycle();
    logic h;
    exp_t n, e;
    #1;
    h = m.valid && m.mr && (m.rda != 5'd0) && id_valid &&
        ((id_uses_rs1 && id_rs1_addr == m.rda) || (id_uses_rs2 && id_rs2_addr == m.rda));
    if (m_known) begin
      check("load_use_stall", 64'(load_use_stall), 64'(h));
      check("id_ready", 64'(id_ready), 64'(flush || (ex_ready && !h)));
    end
    n = m;
    if (rst) n = '0;
    else begin
      if (flush) begin n.valid = 0; n.rw = 0; n.mr = 0; end
      else if (!ex_ready) n = m;
      else if (h || !id_valid) begin n.valid = 0; n.rw = 0; n.mr = 0; end
      else begin
        n.valid = 1; n.pc = id_pc; n.rs1a = id_rs1_addr; n.rs2a = id_rs2_addr;
        n.rda = id_rd_addr; n.d1 = id_rs1_data; n.d2 = id_rs2_data; n.imm = id_imm;
        n.ctrl = id_ctrl; n.rw = id_reg_write; n.mr = id_mem_read;
      end
      if (h && ex_ready && !flush && m.cnt != 4'd15) n.cnt = m.cnt + 4'd1;
    end
    sb.push_back(n);
    @(posedge clk); #1;
    e = sb.pop_front();
    if (rst) m_known = 1;
    check("valid", 64'(id_ex_valid), 64'(e.valid));
    check("reg_write", 64'(id_ex_reg_write), 64'(e.rw));
    check("mem_read", 64'(id_ex_mem_read), 64'(e.mr));
    check("stall_count", 64'(stall_count), 64'(e.cnt));
    if (e.valid) begin
      check("pc", 64'(id_ex_pc), 64'(e.pc));
      check("rs1_addr", 64'(id_ex_rs1_addr), 64'(e.rs1a));
      check("rs2_addr", 64'(id_ex_rs2_addr), 64'(e.rs2a));
      check("rd_addr", 64'(id_ex_rd_addr), 64'(e.rda));
      check("rs1_data", 64'(id_ex_rs1_data), 64'(e.d1));
      check("rs2_data", 64'(id_ex_rs2_data), 64'(e.d2));
      check("imm", 64'(id_ex_imm), 64'(e.imm));
      check("ctrl", 64'(id_ex_ctrl), 64'(e.ctrl));
    end
    m = e;
  endtask

  initial begin
    m = '0;
    rst = 1; ex_ready = 1; flush = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("rst_valid", 64'(id_ex_valid), 64'd0);
    check("rst_count", 64'(stall_count), 64'd0);
    check("rst_pc", 64'(id_ex_pc), 64'd0);
    rst = 0;

    // 1: lw x5 ; add x6,x5,x1
    set_instr(1, 1, 0, 5, 1, 0, 1, 1); cycle();
    set_instr(1, 5, 1, 6, 1, 1, 1, 0);
    #1 check("t1_stall", 64'(load_use_stall), 64'd1);
    cycle();
    check("t1_bubble", 64'(id_ex_valid), 64'd0);
    cycle();
    check("t1_add_rs1", 64'(id_ex_rs1_addr), 64'd5);
    check("t1_count", 64'(stall_count), 64'd1);

    // 2: x0 destination and unused source never stall
    set_instr(1, 1, 0, 0, 1, 0, 1, 1); cycle();
    set_instr(1, 0, 1, 6, 1, 1, 1, 0);
    #1 check("t2_x0", 64'(load_use_stall), 64'd0);
    cycle();
    set_instr(1, 1, 0, 5, 1, 0, 1, 1); cycle();
    set_instr(1, 5, 5, 5, 0, 0, 1, 0);
    #1 check("t2_lui", 64'(load_use_stall), 64'd0);
    cycle();
    check("t2_lui_in", 64'(id_ex_valid), 64'd1);

    // 3: backpressure on an add, then on a load with a dependent in ID
    set_instr(1, 2, 3, 7, 1, 1, 1, 0); cycle();
    ex_ready = 0;
    set_instr(1, 8, 9, 10, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) cycle();
    ex_ready = 1;
    set_instr(1, 1, 0, 12, 1, 0, 1, 1); cycle();
    ex_ready = 0;
    set_instr(1, 12, 1, 13, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) cycle();
    check("t3_count_held", 64'(stall_count), 64'd1);
    check("t3_ready", 64'(id_ready), 64'd0);

    // 4: flush wins over hazard and backpressure
    flush = 1;
    #1 check("t4_ready", 64'(id_ready), 64'd1);
    cycle();
    check("t4_valid", 64'(id_ex_valid), 64'd0);
    check("t4_rw", 64'(id_ex_reg_write), 64'd0);
    flush = 0; ex_ready = 1;
    cycle();

    // 5: saturation with 20 load-use pairs
    rst = 1; cycle(); rst = 0;
    for (int i = 0; i < 20; i++) begin
      set_instr(1, 1, 0, 5'(i % 30 + 1), 1, 0, 1, 1); cycle();
      set_instr(1, 2, 5'(i % 30 + 1), 3, 1, 1, 1, 0); cycle(); cycle();
    end
    check("t5_sat", 64'(stall_count), 64'd15);

    // 6: reset during a hazard
    set_instr(1, 1, 0, 9, 1, 0, 1, 1); cycle();
    set_instr(1, 9, 0, 4, 1, 0, 1, 0);
    #1 check("t6_haz", 64'(load_use_stall), 64'd1);
    rst = 1; cycle(); rst = 0;
    check("t6_valid", 64'(id_ex_valid), 64'd0);
    check("t6_count", 64'(stall_count), 64'd0);
    check("t6_mr", 64'(id_ex_mem_read), 64'd0);
    cycle();
    check("t6_capture", 64'(id_ex_valid), 64'd1);
    check("t6_rs1", 64'(id_ex_rs1_addr), 64'd9);
    id_valid = 0; cycle();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
